// File: rtl/lib_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// lib_arbiter_pkg
// Shared definitions for the pixel-group arbiters.
//   Lvl_ROWS / Lvl_COLS : default level-0 group grid dimensions
//   sched_state_e       : scheduler FSM states (IDLE, GRANT, REL)
// -----------------------------------------------------------------------------
package lib_arbiter_pkg;

   localparam int Lvl_ROWS = 4;
   localparam int Lvl_COLS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      REL   = 2'd2
   } sched_state_e;

endpackage

// File: rtl/rr_pick_onehot.sv
// -----------------------------------------------------------------------------
// rr_pick_onehot
// Combinational round-robin picker. Searches req starting at ptr+1 and
// wrapping, returning the first hit as a one-hot vector plus its index.
// Shared by the level arbiters.
// Ports:
//   req    in  [N-1:0]   request vector
//   ptr    in  [IW-1:0]  last served index (search starts one above it), < N
//   onehot out [N-1:0]   one-hot of the chosen request (0 when none)
//   idx    out [IW-1:0]  index of the chosen request (0 when none)
//   any    out 1         at least one request present
// -----------------------------------------------------------------------------
module rr_pick_onehot #(
   parameter int N  = 16,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;

   always_comb begin
      int  base;
      int  off;
      int  sum;
      logic found;
      // Rotate so that bit 0 of rot is the request at ptr+1.
      dbl   = {req, req};
      base  = int'(ptr) + 1;
      rot   = dbl[base +: N];
      found = 1'b0;
      off   = 0;
      // Lowest set bit of the rotated vector wins.
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            off   = k;
         end
      end
      // Undo the rotation to recover the absolute index.
      sum = base + off;
      if (sum >= N) begin
         sum = sum - N;
      end
      any    = |req;
      idx    = any ? IW'(sum) : '0;
      onehot = '0;
      if (any) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/group_enable_scheduler.sv
// -----------------------------------------------------------------------------
// group_enable_scheduler
// Round-robin scheduler for the level-0 pixel groups. Grants one requesting
// group at a time with a registered one-hot enable, holds the grant until the
// group signals release, then inserts a one-cycle bubble before re-arbitrating.
// The served group becomes lowest priority for the next search.
//
// Optional feature macro: GRP_TIMEOUT_EN
//   defined   : a grant held TMO_CYC cycles without release is forced off and
//               timeout_o pulses for one cycle.
//   undefined : no counter, timeout_o is tied low.
//
// Ports:
//   clk_i          in   clock
//   reset_i        in   synchronous active-high reset
//   req_i          in   [GRP_ROWS][GRP_COLS] per-group request
//   grp_release_i  in   granted group finished (1-cycle pulse)
//   enable_o       out  [GRP_ROWS][GRP_COLS] one-hot group enable
//   x_add_o        out  row of the granted group
//   y_add_o        out  column of the granted group
//   busy_o         out  a grant is held
//   timeout_o      out  1-cycle pulse on forced release
// -----------------------------------------------------------------------------
module group_enable_scheduler
   import lib_arbiter_pkg::*;
#(
   parameter int GRP_ROWS = Lvl_ROWS,
   parameter int GRP_COLS = Lvl_COLS,
   parameter int TMO_CYC  = 255,
   parameter int TMO_W    = 8
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [GRP_ROWS-1:0][GRP_COLS-1:0]    req_i,
   input  logic                                 grp_release_i,
   output logic [GRP_ROWS-1:0][GRP_COLS-1:0]    enable_o,
   output logic [$clog2(GRP_ROWS)-1:0]          x_add_o,
   output logic [$clog2(GRP_COLS)-1:0]          y_add_o,
   output logic                                 busy_o,
   output logic                                 timeout_o
);

   localparam int N  = GRP_ROWS * GRP_COLS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int XW = $clog2(GRP_ROWS);
   localparam int YW = $clog2(GRP_COLS);

   generate
      if (TMO_CYC < 1 || TMO_CYC > (2**TMO_W) - 1) begin : g_bad_tmo
         $error("TMO_CYC must lie in 1..2**TMO_W-1");
      end
   endgenerate

   sched_state_e   state;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  gnt_idx;
   logic [N-1:0]   req_flat;
   logic [N-1:0]   pick_onehot;
   logic [IW-1:0]  pick_idx;
   logic           pick_any;
   logic           tmo_hit;

   // Flat index row*GRP_COLS+col maps directly onto the packed bit order.
   assign req_flat = req_i;

   rr_pick_onehot #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req    (req_flat),
      .ptr    (ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

`ifdef GRP_TIMEOUT_EN
   logic [TMO_W-1:0] tmo_cnt;

   // Next count value reaching TMO_CYC means this is the last GRANT cycle.
   assign tmo_hit = ((tmo_cnt + TMO_W'(1)) == TMO_W'(TMO_CYC));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tmo_cnt   <= '0;
         timeout_o <= 1'b0;
      end else begin
         timeout_o <= (state == GRANT) && !grp_release_i && tmo_hit;
         if (state == GRANT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
         end else begin
            tmo_cnt <= '0;
         end
      end
   end
`else
   assign tmo_hit   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state    <= IDLE;
         enable_o <= '0;
         x_add_o  <= '0;
         y_add_o  <= '0;
         busy_o   <= 1'b0;
         ptr      <= IW'(N - 1);
         gnt_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  enable_o <= pick_onehot;
                  x_add_o  <= XW'(int'(pick_idx) / GRP_COLS);
                  y_add_o  <= YW'(int'(pick_idx) % GRP_COLS);
                  busy_o   <= 1'b1;
                  gnt_idx  <= pick_idx;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // Owner dropping its request is ignored; only release or
               // timeout ends the grant.
               if (grp_release_i || tmo_hit) begin
                  state <= REL;
               end
            end
            REL: begin
               // Bubble cycle: enable drops before the next search so the
               // released group never sees a back-to-back enable.
               enable_o <= '0;
               busy_o   <= 1'b0;
               ptr      <= gnt_idx;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_group_enable_scheduler.sv
module tb_group_enable_scheduler;

   localparam int R = 4;
   localparam int C = 4;
   localparam int N = R * C;

   logic               clk = 1'b0;
   logic               reset_i;
   logic               grp_release;
   logic [R-1:0][C-1:0] req;
   logic [R-1:0][C-1:0] enable;
   logic [1:0]         xa;
   logic [1:0]         ya;
   logic               busy;
   logic               tmo;

   logic [N-1:0]       en_flat;
   logic [20:0]        obs;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int last     = N - 1;   // model: last served index
   int held     = 0;       // model: x/y held value as flat index

   assign en_flat = enable;
   assign obs     = {en_flat, xa, ya, busy};

   always #5 clk = ~clk;

   group_enable_scheduler #(
      .GRP_ROWS (R),
      .GRP_COLS (C),
      .TMO_CYC  (8),
      .TMO_W    (8)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset_i),
      .req_i         (req),
      .grp_release_i (grp_release),
      .enable_o      (enable),
      .x_add_o       (xa),
      .y_add_o       (ya),
      .busy_o        (busy),
      .timeout_o     (tmo)
   );

   // Reference: the winner is the requester at the smallest forward distance
   // from the last served group; the last served group itself is farthest.
   function automatic int model_pick(logic [N-1:0] r, int lst);
      int best  = -1;
      int bestd = N + 1;
      for (int n = 0; n < N; n++) begin
         if (r[n]) begin
            int d = (n - lst - 1 + 2 * N) % N;
            if (d < bestd) begin
               bestd = d;
               best  = n;
            end
         end
      end
      return best;
   endfunction

   function automatic logic [20:0] busy_vec(int n);
      logic [15:0] oh;
      oh    = '0;
      oh[n] = 1'b1;
      return {oh, 2'(n / C), 2'(n % C), 1'b1};
   endfunction

   function automatic logic [20:0] idle_vec(int h);
      return {16'h0, 2'(h / C), 2'(h % C), 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Release the current grant g and return to IDLE with no requests.
   task automatic finish_grant(int g);
      grp_release = 1'b1;
      tick();
      grp_release = 1'b0;
      req = '0;
      tick();
      last = g;
      held = g;
      chk_cnt++;
      if (obs !== idle_vec(g))
         $display("FAIL rel_bubble obs=%h exp=%h", obs, idle_vec(g));
      else pass_cnt++;
   endtask

   task automatic test_reset();
      req = '1;
      grp_release = 1'b0;
      reset_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk_cnt++;
         if ({obs, tmo} !== {idle_vec(0), 1'b0})
            $display("FAIL reset_state obs=%h exp=%h", {obs, tmo}, {idle_vec(0), 1'b0});
         else pass_cnt++;
      end
      reset_i = 1'b0;
      last = N - 1;
      held = 0;
      tick();
      chk_cnt++;
      if (obs !== busy_vec(0))
         $display("FAIL first_grant obs=%h exp=%h", obs, busy_vec(0));
      else pass_cnt++;
      finish_grant(0);
   endtask

   task automatic test_single();
      req = '0;
      req[2][1] = 1'b1;
      tick();
      chk_cnt++;
      if (obs !== busy_vec(9))
         $display("FAIL single_grant obs=%h exp=%h", obs, busy_vec(9));
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_cnt++;
         if (obs !== busy_vec(9))
            $display("FAIL single_hold obs=%h exp=%h", obs, busy_vec(9));
         else pass_cnt++;
      end
      grp_release = 1'b1;
      tick();
      grp_release = 1'b0;
      tick();
      last = 9;
      held = 9;
      chk_cnt++;
      if (obs !== idle_vec(9))
         $display("FAIL single_gap obs=%h exp=%h", obs, idle_vec(9));
      else pass_cnt++;
      tick();
      chk_cnt++;
      if (obs !== busy_vec(9))
         $display("FAIL single_regrant obs=%h exp=%h", obs, busy_vec(9));
      else pass_cnt++;
      finish_grant(9);
   endtask

   task automatic test_all_round();
      bit seen [N];
      int distinct = 0;
      for (int i = 0; i < N; i++) seen[i] = 1'b0;
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      last = N - 1;
      held = 0;
      req = '1;
      for (int g = 0; g <= N; g++) begin
         int exp;
         int got;
         tick();
         exp = model_pick(req, last);
         got = int'(xa) * C + int'(ya);
         if (g < N && !seen[got]) begin
            seen[got] = 1'b1;
            distinct++;
         end
         chk_cnt++;
         if (obs !== busy_vec(exp))
            $display("FAIL round_grant g=%0d obs=%h exp=%h", g, obs, busy_vec(exp));
         else pass_cnt++;
         tick();
         tick();
         grp_release = 1'b1;
         tick();
         grp_release = 1'b0;
         tick();
         last = exp;
         held = exp;
         chk_cnt++;
         if (obs !== idle_vec(exp))
            $display("FAIL round_gap g=%0d obs=%h exp=%h", g, obs, idle_vec(exp));
         else pass_cnt++;
      end
      chk_cnt++;
      if (distinct !== N)
         $display("FAIL round_distinct got=%0d exp=%0d", distinct, N);
      else pass_cnt++;
      req = '0;
      tick();
   endtask

   task automatic test_random();
      for (int rnd = 0; rnd < 40; rnd++) begin
         logic [N-1:0] r;
         int exp;
         int hold;
         r = 16'($urandom);
         if (rnd % 5 == 0) r = '0;
         req = r;
         if (r == '0) begin
            tick();
            tick();
            chk_cnt++;
            if (obs !== idle_vec(held))
               $display("FAIL rand_idle obs=%h exp=%h", obs, idle_vec(held));
            else pass_cnt++;
            r = 16'(1 << $urandom_range(0, N - 1)) | 16'($urandom);
            req = r;
         end
         tick();
         exp = model_pick(r, last);
         chk_cnt++;
         if (obs !== busy_vec(exp))
            $display("FAIL rand_grant obs=%h exp=%h", obs, busy_vec(exp));
         else pass_cnt++;
         hold = $urandom_range(0, 4);
         for (int h = 0; h < hold; h++) begin
            req = 16'($urandom);
            tick();
            chk_cnt++;
            if (obs !== busy_vec(exp))
               $display("FAIL rand_hold obs=%h exp=%h", obs, busy_vec(exp));
            else pass_cnt++;
         end
         grp_release = 1'b1;
         if ($urandom_range(0, 1) == 1) req = 16'($urandom);
         tick();
         grp_release = 1'b0;
         tick();
         last = exp;
         held = exp;
         chk_cnt++;
         if (obs !== idle_vec(exp))
            $display("FAIL rand_bubble obs=%h exp=%h", obs, idle_vec(exp));
         else pass_cnt++;
      end
      req = '0;
      tick();
   endtask

   task automatic test_withdraw();
      logic [N-1:0] r;
      int exp;
      req = '0;
      grp_release = 1'b1;
      tick();
      grp_release = 1'b0;
      chk_cnt++;
      if (obs !== idle_vec(held))
         $display("FAIL rel_in_idle obs=%h exp=%h", obs, idle_vec(held));
      else pass_cnt++;
      r = 16'(1 << $urandom_range(0, N - 1)) | 16'($urandom);
      req = r;
      tick();
      exp = model_pick(r, last);
      chk_cnt++;
      if (obs !== busy_vec(exp))
         $display("FAIL withdraw_grant obs=%h exp=%h", obs, busy_vec(exp));
      else pass_cnt++;
      req = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_cnt++;
         if (obs !== busy_vec(exp))
            $display("FAIL withdraw_hold obs=%h exp=%h", obs, busy_vec(exp));
         else pass_cnt++;
      end
      finish_grant(exp);
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] r;
      int exp;
      r = 16'(1 << $urandom_range(1, N - 1));
      req = r;
      tick();
      exp = model_pick(r, last);
      chk_cnt++;
      if (obs !== busy_vec(exp))
         $display("FAIL midrst_grant obs=%h exp=%h", obs, busy_vec(exp));
      else pass_cnt++;
      reset_i = 1'b1;
      tick();
      chk_cnt++;
      if (obs !== idle_vec(0))
         $display("FAIL midrst_drop obs=%h exp=%h", obs, idle_vec(0));
      else pass_cnt++;
      reset_i = 1'b0;
      last = N - 1;
      held = 0;
      req = '1;
      tick();
      chk_cnt++;
      if (obs !== busy_vec(0))
         $display("FAIL midrst_ptr obs=%h exp=%h", obs, busy_vec(0));
      else pass_cnt++;
      finish_grant(0);
   endtask

   task automatic test_timeout();
      int exp;
      req = '0;
      req[0][3] = 1'b1;
      req[1][3] = 1'b1;
      tick();
      exp = model_pick(req, last);
      chk_cnt++;
      if (obs !== busy_vec(exp))
         $display("FAIL tmo_grant obs=%h exp=%h", obs, busy_vec(exp));
      else pass_cnt++;
`ifdef GRP_TIMEOUT_EN
      for (int k = 1; k < 8; k++) begin
         tick();
         chk_cnt++;
         if ({obs, tmo} !== {busy_vec(exp), 1'b0})
            $display("FAIL tmo_wait k=%0d obs=%h exp=%h", k, {obs, tmo}, {busy_vec(exp), 1'b0});
         else pass_cnt++;
      end
      tick();
      chk_cnt++;
      if (tmo !== 1'b1)
         $display("FAIL tmo_pulse got=%b exp=1", tmo);
      else pass_cnt++;
      tick();
      last = exp;
      held = exp;
      chk_cnt++;
      if ({obs, tmo} !== {idle_vec(exp), 1'b0})
         $display("FAIL tmo_bubble obs=%h exp=%h", {obs, tmo}, {idle_vec(exp), 1'b0});
      else pass_cnt++;
      tick();
      exp = model_pick(req, last);
      chk_cnt++;
      if (obs !== busy_vec(exp))
         $display("FAIL tmo_next obs=%h exp=%h", obs, busy_vec(exp));
      else pass_cnt++;
`else
      for (int k = 0; k < 100; k++) begin
         tick();
         chk_cnt++;
         if ({obs, tmo} !== {busy_vec(exp), 1'b0})
            $display("FAIL no_tmo_hold k=%0d obs=%h exp=%h", k, {obs, tmo}, {busy_vec(exp), 1'b0});
         else pass_cnt++;
      end
`endif
      finish_grant(exp);
   endtask

   initial begin
      reset_i     = 1'b1;
      grp_release = 1'b0;
      req         = '0;
      test_reset();
      test_single();
      test_all_round();
      test_random();
      test_withdraw();
      test_reset_mid();
      test_timeout();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached passed=%0d total=%0d", pass_cnt, chk_cnt);
      $fatal(1, "watchdog");
   end

endmodule
